// File: rtl/demo_pkg.sv
// Shared encodings for the demo scene timeline: phase codes, scene indices
// and the fade level width.
package demo_pkg;

    localparam int FADE_W = 6;
    localparam logic [FADE_W-1:0] FADE_MAX = '1;

    typedef enum logic [1:0] {
        FADE_IN   = 2'd0,
        HOLD      = 2'd1,
        FADE_OUT  = 2'd2,
        PHASE_BAD = 2'd3
    } phase_e;

    localparam logic [1:0] SCENE_BARS  = 2'd0;
    localparam logic [1:0] SCENE_STARS = 2'd1;
    localparam logic [1:0] SCENE_PLANE = 2'd2;
    localparam logic [1:0] SCENE_OUTRO = 2'd3;

endpackage

// File: rtl/fade_ramp.sv
// Global brightness register with saturating step up/down.
// at_max / at_min flag that the pending up/down step lands on the rail.
module fade_ramp
    import demo_pkg::*;
(
    input  logic              clk48,
    input  logic              rst,
    input  logic              up,
    input  logic              down,
    input  logic [FADE_W-1:0] step,
    output logic [FADE_W-1:0] level,
    output logic              at_max,
    output logic              at_min
);

    logic [FADE_W-1:0]        level_q;
    logic [FADE_W-1:0]        level_d;
    logic [FADE_W:0]          sum;
    logic signed [FADE_W:0]   diff;

    always_comb begin
        sum     = {1'b0, level_q} + {1'b0, step};
        diff    = $signed({1'b0, level_q}) - $signed({1'b0, step});
        at_max  = (sum >= {1'b0, FADE_MAX});
        at_min  = diff[FADE_W] || (diff == '0);
        level_d = level_q;
        if (up) begin
            level_d = at_max ? FADE_MAX : sum[FADE_W-1:0];
        end else if (down) begin
            level_d = at_min ? '0 : diff[FADE_W-1:0];
        end
    end

    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/demo_sequencer.sv
// Per-frame scene controller: walks bars -> stars -> plane -> outro, each
// scene fading in, holding, and fading out; drives layer enables and fade.
module demo_sequencer
    import demo_pkg::*;
#(
    parameter int SCENE0_FRAMES = 240,
    parameter int SCENE1_FRAMES = 600,
    parameter int SCENE2_FRAMES = 900,
    parameter int SCENE3_FRAMES = 120,
    parameter int FADE_STEP     = 2
) (
    input  logic              clk48,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              pause_n,
    input  logic              skip,
    output logic [1:0]        scene,
    output logic [1:0]        phase,
    output logic [FADE_W-1:0] fade,
    output logic [9:0]        scene_frame,
    output logic [10:0]       frame_count,
    output logic              en_colorbar,
    output logic              en_stars,
    output logic              en_scroll,
    output logic              en_plane,
    output logic              scene_changed
);

    // Scene ROM: index of the last HOLD frame, and {colorbar, stars, scroll, plane}.
    function automatic logic [9:0] hold_last(input logic [1:0] s);
        case (s)
            SCENE_BARS:  hold_last = 10'(SCENE0_FRAMES - 1);
            SCENE_STARS: hold_last = 10'(SCENE1_FRAMES - 1);
            SCENE_PLANE: hold_last = 10'(SCENE2_FRAMES - 1);
            default:     hold_last = 10'(SCENE3_FRAMES - 1);
        endcase
    endfunction

    function automatic logic [3:0] layer_mask(input logic [1:0] s);
        case (s)
            SCENE_BARS:  layer_mask = 4'b1000;
            SCENE_STARS: layer_mask = 4'b0110;
            SCENE_PLANE: layer_mask = 4'b0111;
            default:     layer_mask = 4'b0010;
        endcase
    endfunction

    phase_e      phase_q;
    logic [1:0]  scene_q;
    logic [1:0]  scene_d;
    logic [9:0]  sf_q;
    logic [10:0] fc_q;
    logic [3:0]  en_q;
    logic        chg_q;

    logic tick;
    logic skip_ok;
    logic ramp_up;
    logic ramp_down;
    logic at_max;
    logic at_min;

    assign tick      = frame_start & pause_n;
    assign skip_ok   = skip & pause_n & ((phase_q == FADE_IN) | (phase_q == HOLD));
    // An accepted skip takes the phase change instead of the fade step.
    assign ramp_up   = tick & ~skip_ok & (phase_q == FADE_IN);
    assign ramp_down = tick & (phase_q == FADE_OUT);

    always_comb begin
        scene_d = scene_q;
        if (ramp_down && at_min) begin
            scene_d = scene_q + 2'd1;
        end
    end

    fade_ramp u_ramp (
        .clk48  (clk48),
        .rst    (rst),
        .up     (ramp_up),
        .down   (ramp_down),
        .step   (FADE_W'(FADE_STEP)),
        .level  (fade),
        .at_max (at_max),
        .at_min (at_min)
    );

    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            phase_q <= FADE_IN;
            scene_q <= SCENE_BARS;
            sf_q    <= '0;
            fc_q    <= '0;
            en_q    <= layer_mask(SCENE_BARS);
            chg_q   <= 1'b0;
        end else begin
            scene_q <= scene_d;
            en_q    <= layer_mask(scene_d);
            chg_q   <= (scene_d != scene_q);
            if (tick) begin
                fc_q <= fc_q + 11'd1;
            end
            case (phase_q)
                FADE_IN: begin
                    if (skip_ok) begin
                        phase_q <= FADE_OUT;
                    end else if (tick && at_max) begin
                        phase_q <= HOLD;
                        sf_q    <= '0;
                    end
                end
                HOLD: begin
                    if (skip_ok) begin
                        phase_q <= FADE_OUT;
                    end else if (tick) begin
                        if (sf_q == hold_last(scene_q)) begin
                            phase_q <= FADE_OUT;
                        end else begin
                            sf_q <= sf_q + 10'd1;
                        end
                    end
                end
                FADE_OUT: begin
                    if (tick && at_min) begin
                        phase_q <= FADE_IN;
                        sf_q    <= '0;
                    end
                end
                default: phase_q <= FADE_IN;
            endcase
        end
    end

    assign scene         = scene_q;
    assign phase         = phase_q;
    assign scene_frame   = sf_q;
    assign frame_count   = fc_q;
    assign {en_colorbar, en_stars, en_scroll, en_plane} = en_q;
    assign scene_changed = chg_q;

endmodule

// File: tb/tb_demo_sequencer.sv
// Scoreboard bench for demo_sequencer: default instance plus a short-scene,
// FADE_STEP=5 instance, both sharing stimulus and checked against a model.
module tb_demo_sequencer;

    logic clk48 = 1'b0;
    logic rst = 1'b1;
    logic frame_start = 1'b0;
    logic pause_n = 1'b1;
    logic skip = 1'b0;

    logic [1:0]  scene0, phase0, scene1, phase1;
    logic [5:0]  fade0, fade1;
    logic [9:0]  sf0, sf1;
    logic [10:0] fc0, fc1;
    logic        cb0, st0, sc0, pl0, chg0;
    logic        cb1, st1, sc1, pl1, chg1;

    always #5 clk48 = ~clk48;

    demo_sequencer dut0 (
        .clk48(clk48), .rst(rst), .frame_start(frame_start), .pause_n(pause_n), .skip(skip),
        .scene(scene0), .phase(phase0), .fade(fade0), .scene_frame(sf0), .frame_count(fc0),
        .en_colorbar(cb0), .en_stars(st0), .en_scroll(sc0), .en_plane(pl0), .scene_changed(chg0)
    );

    demo_sequencer #(
        .SCENE0_FRAMES(5), .SCENE1_FRAMES(7), .SCENE2_FRAMES(3), .SCENE3_FRAMES(4), .FADE_STEP(5)
    ) dut1 (
        .clk48(clk48), .rst(rst), .frame_start(frame_start), .pause_n(pause_n), .skip(skip),
        .scene(scene1), .phase(phase1), .fade(fade1), .scene_frame(sf1), .frame_count(fc1),
        .en_colorbar(cb1), .en_stars(st1), .en_scroll(sc1), .en_plane(pl1), .scene_changed(chg1)
    );

    logic [35:0] act0, act1;
    assign act0 = {scene0, phase0, fade0, sf0, fc0, cb0, st0, sc0, pl0, chg0};
    assign act1 = {scene1, phase1, fade1, sf1, fc1, cb1, st1, sc1, pl1, chg1};

    // Reference model: phase 0 fade-in, 1 hold, 2 fade-out.
    int m_scene[2], m_phase[2], m_fade[2], m_sf[2], m_fc[2];
    bit m_chg[2];
    int m_step[2] = '{2, 5};
    int m_hold[2][4] = '{'{240, 600, 900, 120}, '{5, 7, 3, 4}};

    int n_checks = 0;
    int n_errors = 0;

    logic [35:0] q0[$];
    logic [35:0] q1[$];

    function automatic logic [3:0] layers(int s);
        case (s)
            0:       return 4'b1000;
            1:       return 4'b0110;
            2:       return 4'b0111;
            default: return 4'b0010;
        endcase
    endfunction

    function automatic logic [35:0] pack_model(int k);
        return {2'(m_scene[k]), 2'(m_phase[k]), 6'(m_fade[k]), 10'(m_sf[k]),
                11'(m_fc[k]), layers(m_scene[k]), m_chg[k]};
    endfunction

    task automatic model_reset(int k);
        m_scene[k] = 0;
        m_phase[k] = 0;
        m_fade[k]  = 0;
        m_sf[k]    = 0;
        m_fc[k]    = 0;
        m_chg[k]   = 1'b0;
    endtask

    task automatic model_step(int k, bit fs, bit pn, bit sk);
        bit tk;
        bit sk_ok;
        if (rst) begin
            model_reset(k);
        end else begin
            tk    = fs && pn;
            sk_ok = sk && pn && (m_phase[k] == 0 || m_phase[k] == 1);
            m_chg[k] = 1'b0;
            if (tk) m_fc[k] = (m_fc[k] + 1) % 2048;
            if (sk_ok) begin
                m_phase[k] = 2;
            end else if (tk) begin
                case (m_phase[k])
                    0: begin
                        m_fade[k] = (m_fade[k] + m_step[k] > 63) ? 63 : m_fade[k] + m_step[k];
                        if (m_fade[k] == 63) begin
                            m_phase[k] = 1;
                            m_sf[k] = 0;
                        end
                    end
                    1: begin
                        if (m_sf[k] == m_hold[k][m_scene[k]] - 1) m_phase[k] = 2;
                        else m_sf[k] = m_sf[k] + 1;
                    end
                    2: begin
                        m_fade[k] = (m_fade[k] - m_step[k] < 0) ? 0 : m_fade[k] - m_step[k];
                        if (m_fade[k] == 0) begin
                            m_scene[k] = (m_scene[k] + 1) % 4;
                            m_phase[k] = 0;
                            m_sf[k] = 0;
                            m_chg[k] = 1'b1;
                        end
                    end
                    default: m_phase[k] = 0;
                endcase
            end
        end
    endtask

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_vec(string name, logic [35:0] act, logic [35:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: one expected state per clock edge, compared just after the edge.
    always @(posedge clk48) begin
        #1;
        if (q0.size() > 0) chk_vec("sb_dut0", act0, q0.pop_front());
        if (q1.size() > 0) chk_vec("sb_dut1", act1, q1.pop_front());
    end

    task automatic drive(bit fs, bit pn, bit sk);
        @(negedge clk48);
        frame_start = fs;
        pause_n     = pn;
        skip        = sk;
        model_step(0, fs, pn, sk);
        model_step(1, fs, pn, sk);
        q0.push_back(pack_model(0));
        q1.push_back(pack_model(1));
    endtask

    task automatic pulse(bit pn, bit sk);
        drive(1'b1, pn, sk);
        drive(1'b0, pn, 1'b0);
    endtask

    task automatic drive_random();
        drive(1'($urandom_range(0, 1)), ($urandom_range(0, 9) != 0), ($urandom_range(0, 99) == 0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        bit wrapped;
        int fc_before;

        model_reset(0);
        model_reset(1);
        drive(0, 1, 0);
        drive(0, 1, 0);
        rst = 1'b0;
        chk("rst_scene", scene0, 0);
        chk("rst_phase", phase0, 0);
        chk("rst_fade", fade0, 0);
        chk("rst_scene_frame", sf0, 0);
        chk("rst_frame_count", fc0, 0);
        chk("rst_en_colorbar", cb0, 1);
        chk("rst_en_stars", st0, 0);
        chk("rst_changed", chg0, 0);

        repeat (32) pulse(1, 0);
        chk("fadein_fade", fade0, 63);
        chk("fadein_phase", phase0, 1);
        chk("fadein_scene_frame", sf0, 0);
        chk("fadein_colorbar", cb0, 1);

        repeat (240) pulse(1, 0);
        chk("hold_end_phase", phase0, 2);
        chk("hold_end_scene_frame", sf0, 239);

        repeat (32) pulse(1, 0);
        chk("s1_scene", scene0, 1);
        chk("s1_fade", fade0, 0);
        chk("s1_changed", chg0, 1);
        chk("s1_stars", st0, 1);
        chk("s1_scroll", sc0, 1);
        chk("s1_colorbar", cb0, 0);
        drive(0, 1, 0);
        chk("s1_changed_drop", chg0, 0);

        repeat (37) pulse(1, 0);
        chk("pause_pre_sf", sf0, 5);
        fc_before = m_fc[0];
        repeat (50) pulse(0, 1'($urandom_range(0, 1)));
        chk("pause_sf", sf0, 5);
        chk("pause_fade", fade0, 63);
        chk("pause_fc", fc0, fc_before);
        chk("pause_phase", phase0, 1);
        pulse(1, 0);
        chk("unpause_sf", sf0, 6);

        repeat (4) pulse(1, 0);
        chk("skip_pre_sf", sf0, 10);
        drive(0, 1, 1);
        drive(0, 1, 0);
        chk("skip_phase", phase0, 2);
        chk("skip_fade", fade0, 63);
        drive(0, 1, 1);
        drive(0, 1, 0);
        chk("skip2_phase", phase0, 2);
        chk("skip2_fade", fade0, 63);
        chk("skip2_sf", sf0, 10);

        repeat (32) pulse(1, 0);
        chk("s2_scene", scene0, 2);
        chk("s2_plane", pl0, 1);
        repeat (20) pulse(1, 0);
        chk("coll_pre_fade", fade0, 40);
        fc_before = m_fc[0];
        drive(1, 1, 1);
        drive(0, 1, 0);
        chk("coll_phase", phase0, 2);
        chk("coll_fade", fade0, 40);
        chk("coll_fc", fc0, (fc_before + 1) % 2048);

        guard = 0;
        wrapped = 1'b0;
        while (!wrapped && guard < 6000) begin
            drive_random();
            guard++;
            if (m_chg[0] && m_scene[0] == 0) wrapped = 1'b1;
        end
        chk("wrap_reached", int'(wrapped), 1);
        drive(0, 1, 0);
        chk("wrap_scene", scene0, 0);
        chk("wrap_colorbar", cb0, 1);
        chk("wrap_scroll", sc0, 0);

        guard = 0;
        while (m_phase[0] != 1 && guard < 200) begin
            pulse(1, 0);
            guard++;
        end
        chk("arst_pre_hold", phase0, 1);
        drive(0, 1, 1);
        drive(0, 1, 0);
        repeat (3) pulse(1, 0);
        chk("arst_pre_phase", phase0, 2);
        chk("arst_pre_fade", fade0, 57);

        @(posedge clk48);
        #3;
        rst = 1'b1;
        #1;
        model_reset(0);
        model_reset(1);
        chk_vec("arst_dut0", act0, pack_model(0));
        chk_vec("arst_dut1", act1, pack_model(1));
        chk("arst_fade", fade0, 0);
        drive(0, 1, 0);
        drive(0, 1, 0);
        rst = 1'b0;
        repeat (60) drive_random();

        @(posedge clk48);
        #2;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
